// File: rtl/frame_buffer_pp.sv
// Ping-pong frame buffer: a writer fills one bank while a reader scans the other.
// Define FB_DROP_CNT_EN to add the saturating dropped-frame counter and its port.
module frame_buffer_pp #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 19,
    parameter int DEPTH  = 307200
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_sof,
    input  logic              wr_eof,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_sof,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              frame_ready,
    output logic              wr_bank,
    output logic              rd_bank
`ifdef FB_DROP_CNT_EN
    ,
    output logic [15:0]       drop_cnt
`endif
);

    localparam int MEM_W = $clog2(2 * DEPTH);
    localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(DEPTH);
    localparam logic [MEM_W-1:0] BASE = MEM_W'(DEPTH);

    typedef enum logic [1:0] {
        W_IDLE,
        W_FILL,
        W_HOLD
    } state_t;

    state_t state;
    state_t state_nx;
    logic   bank;
    logic   swap;
    logic   wr_go;
    logic   wr_sel;

    logic [DATA_W-1:0] mem [0:2*DEPTH-1];
    logic [MEM_W-1:0]  wr_idx;
    logic [MEM_W-1:0]  rd_idx;
    logic              wr_in_range;
    logic              rd_in_range;

    // bank is the reader's bank; the writer always owns the other one
    assign rd_bank     = bank;
    assign wr_bank     = ~bank;
    assign frame_ready = (state == W_HOLD);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= W_IDLE;
            bank  <= 1'b0;
        end else begin
            state <= state_nx;
            if (swap) bank <= ~bank;
        end
    end

    always_comb begin
        state_nx = state;
        swap     = 1'b0;
        wr_go    = 1'b0;
        wr_sel   = ~bank;
        unique case (state)
            W_IDLE: begin
                if (wr_sof) begin
                    state_nx = W_FILL;
                    wr_go    = wr_en;
                end
            end
            W_FILL: begin
                wr_go = wr_en;
                if (!wr_sof && wr_eof) state_nx = W_HOLD;
            end
            W_HOLD: begin
                if (rd_sof) begin
                    // first pixel of a swapping frame goes to the bank being released
                    swap     = 1'b1;
                    wr_sel   = bank;
                    wr_go    = wr_sof & wr_en;
                    state_nx = wr_sof ? W_FILL : W_IDLE;
                end else if (wr_sof) begin
                    wr_go    = wr_en;
                    state_nx = W_FILL;
                end
            end
            default: state_nx = W_IDLE;
        endcase
    end

    assign wr_in_range = ({1'b0, wr_addr} < LIMIT);
    assign rd_in_range = ({1'b0, rd_addr} < LIMIT);
    assign wr_idx = wr_sel ? BASE + MEM_W'(wr_addr) : MEM_W'(wr_addr);
    assign rd_idx = bank ? BASE + MEM_W'(rd_addr) : MEM_W'(rd_addr);

    always_ff @(posedge clk) begin
        if (!rst && wr_go && wr_in_range) mem[wr_idx] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) rd_data <= rd_in_range ? mem[rd_idx] : '0;
        end
    end

`ifdef FB_DROP_CNT_EN
    logic drop;

    assign drop = (state == W_HOLD) && wr_sof && !rd_sof;

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (drop && drop_cnt != 16'hFFFF) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_frame_buffer_pp.sv
// Scoreboard bench for frame_buffer_pp: expected read data is queued at issue
// and retired when rd_valid appears; control outputs are checked per scenario.
module tb_frame_buffer_pp;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_sof = 1'b0;
    logic        wr_eof = 1'b0;
    logic        wr_en = 1'b0;
    logic [18:0] wr_addr = '0;
    logic [7:0]  wr_data = '0;
    logic        rd_sof = 1'b0;
    logic        rd_en = 1'b0;
    logic [18:0] rd_addr = '0;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        frame_ready;
    logic        wr_bank;
    logic        rd_bank;
`ifdef FB_DROP_CNT_EN
    logic [15:0] drop_cnt;
`endif

    int checks = 0;
    int failures = 0;
    logic [7:0] sb[$];

    frame_buffer_pp dut (
        .clk(clk),
        .rst(rst),
        .wr_sof(wr_sof),
        .wr_eof(wr_eof),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .rd_sof(rd_sof),
        .rd_en(rd_en),
        .rd_addr(rd_addr),
        .rd_data(rd_data),
        .rd_valid(rd_valid),
        .frame_ready(frame_ready),
        .wr_bank(wr_bank),
        .rd_bank(rd_bank)
`ifdef FB_DROP_CNT_EN
        ,
        .drop_cnt(drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    // scoreboard retire: every rd_valid must match the oldest queued expectation
    always @(negedge clk) begin
        if (rd_valid === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected: rd_valid=1 rd_data=%h with nothing queued", rd_data);
            end else begin
                logic [7:0] exp;
                exp = sb.pop_front();
                if (rd_data !== exp) begin
                    failures++;
                    $display("FAIL sb_data: got %h expected %h", rd_data, exp);
                end
            end
        end
    end

    task automatic cyc(input logic sof, input logic eof, input logic we,
                       input logic [18:0] wa, input logic [7:0] wd,
                       input logic rsof, input logic re,
                       input logic [18:0] ra, input logic [7:0] rexp);
        wr_sof  = sof;
        wr_eof  = eof;
        wr_en   = we;
        wr_addr = wa;
        wr_data = wd;
        rd_sof  = rsof;
        rd_en   = re;
        rd_addr = ra;
        if (re && !rst) sb.push_back(rexp);
        @(negedge clk);
        wr_sof = 1'b0;
        wr_eof = 1'b0;
        wr_en  = 1'b0;
        rd_sof = 1'b0;
        rd_en  = 1'b0;
    endtask

    task automatic drain(input string name);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL %s_drain: %0d reads outstanding, expected 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checks += 5;
        if (frame_ready !== 1'b0) begin failures++; $display("FAIL rst_ready: %b exp 0", frame_ready); end
        if (wr_bank !== 1'b1) begin failures++; $display("FAIL rst_wr_bank: %b exp 1", wr_bank); end
        if (rd_bank !== 1'b0) begin failures++; $display("FAIL rst_rd_bank: %b exp 0", rd_bank); end
        if (rd_valid !== 1'b0) begin failures++; $display("FAIL rst_valid: %b exp 0", rd_valid); end
        if (rd_data !== 8'h00) begin failures++; $display("FAIL rst_data: %h exp 00", rd_data); end
`ifdef FB_DROP_CNT_EN
        checks++;
        if (drop_cnt !== 16'd0) begin failures++; $display("FAIL rst_drop: %0d exp 0", drop_cnt); end
`endif
    endtask

    task automatic test_basic();
        cyc(1, 0, 1, 19'd0, 8'h11, 0, 0, 0, 0);
        cyc(0, 0, 1, 19'd1, 8'h22, 0, 0, 0, 0);
        cyc(0, 0, 1, 19'd2, 8'h33, 0, 0, 0, 0);
        cyc(0, 1, 1, 19'd3, 8'h44, 0, 0, 0, 0);
        checks += 3;
        if (frame_ready !== 1'b1) begin failures++; $display("FAIL basic_ready: %b exp 1", frame_ready); end
        if (wr_bank !== 1'b1) begin failures++; $display("FAIL basic_wr_bank: %b exp 1", wr_bank); end
        if (rd_bank !== 1'b0) begin failures++; $display("FAIL basic_rd_bank: %b exp 0", rd_bank); end
        cyc(0, 0, 0, 0, 0, 1, 0, 0, 0);
        checks += 3;
        if (rd_bank !== 1'b1) begin failures++; $display("FAIL swap_rd_bank: %b exp 1", rd_bank); end
        if (wr_bank !== 1'b0) begin failures++; $display("FAIL swap_wr_bank: %b exp 0", wr_bank); end
        if (frame_ready !== 1'b0) begin failures++; $display("FAIL swap_ready: %b exp 0", frame_ready); end
        cyc(0, 0, 0, 0, 0, 0, 1, 19'd2, 8'h33);
        drain("basic");
    endtask

    task automatic test_back_to_back();
        cyc(0, 0, 0, 0, 0, 0, 1, 19'd0, 8'h11);
        cyc(0, 0, 0, 0, 0, 0, 1, 19'd1, 8'h22);
        cyc(0, 0, 0, 0, 0, 0, 1, 19'd3, 8'h44);
        @(negedge clk);
        checks += 2;
        if (rd_valid !== 1'b0) begin failures++; $display("FAIL hold_valid: %b exp 0", rd_valid); end
        if (rd_data !== 8'h44) begin failures++; $display("FAIL hold_data: %h exp 44", rd_data); end
        drain("b2b");
    endtask

    task automatic test_drop();
        cyc(1, 0, 1, 19'd0, 8'hAA, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 1, 19'd0, 8'hBB, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
        checks += 2;
        if (frame_ready !== 1'b1) begin failures++; $display("FAIL drop_ready: %b exp 1", frame_ready); end
        if (wr_bank !== 1'b0) begin failures++; $display("FAIL drop_wr_bank: %b exp 0", wr_bank); end
`ifdef FB_DROP_CNT_EN
        checks++;
        if (drop_cnt !== 16'd1) begin failures++; $display("FAIL drop_cnt: %0d exp 1", drop_cnt); end
`endif
        // read in the rd_sof cycle still targets the old bank
        cyc(0, 0, 0, 0, 0, 1, 1, 19'd2, 8'h33);
        cyc(0, 0, 0, 0, 0, 0, 1, 19'd0, 8'hBB);
        drain("drop");
    endtask

    task automatic test_same_cycle();
        cyc(1, 0, 1, 19'd0, 8'hC1, 0, 0, 0, 0);
        cyc(0, 0, 1, 19'd1, 8'hC2, 0, 0, 0, 0);
        cyc(0, 1, 1, 19'd2, 8'hC3, 0, 0, 0, 0);
        cyc(1, 0, 1, 19'd1, 8'hD1, 1, 1, 19'd0, 8'hBB);
        checks += 3;
        if (rd_bank !== 1'b1) begin failures++; $display("FAIL both_rd_bank: %b exp 1", rd_bank); end
        if (wr_bank !== 1'b0) begin failures++; $display("FAIL both_wr_bank: %b exp 0", wr_bank); end
        if (frame_ready !== 1'b0) begin failures++; $display("FAIL both_ready: %b exp 0", frame_ready); end
        cyc(0, 0, 1, 19'd2, 8'hD2, 0, 1, 19'd0, 8'hC1);
        cyc(0, 1, 0, 0, 0, 0, 1, 19'd1, 8'hC2);
        checks++;
        if (frame_ready !== 1'b1) begin failures++; $display("FAIL both_ready2: %b exp 1", frame_ready); end
`ifdef FB_DROP_CNT_EN
        checks++;
        if (drop_cnt !== 16'd1) begin failures++; $display("FAIL both_drop: %0d exp 1", drop_cnt); end
`endif
        cyc(0, 0, 0, 0, 0, 0, 1, 19'd2, 8'hC3);
        cyc(0, 0, 0, 0, 0, 0, 1, 19'd3, 8'h44);
        cyc(0, 0, 0, 0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 19'd0, 8'hBB);
        cyc(0, 0, 0, 0, 0, 0, 1, 19'd1, 8'hD1);
        cyc(0, 0, 0, 0, 0, 0, 1, 19'd2, 8'hD2);
        drain("both");
    endtask

    task automatic test_out_of_range();
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 0, 0, 0);
        cyc(1, 0, 1, 19'd307200, 8'hEE, 0, 0, 0, 0);
        cyc(0, 0, 1, 19'd0, 8'h5A, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 1, 19'd0, 8'hC1);
        cyc(0, 0, 0, 0, 0, 0, 1, 19'd307200, 8'h00);
        cyc(0, 0, 0, 0, 0, 0, 1, 19'd524287, 8'h00);
        cyc(0, 0, 0, 0, 0, 1, 1, 19'd1, 8'hC2);
        cyc(0, 0, 0, 0, 0, 0, 1, 19'd0, 8'h5A);
        // idle: wr_en and wr_eof ignored, rd_sof does not swap
        cyc(0, 1, 1, 19'd1, 8'h77, 0, 0, 0, 0);
        checks++;
        if (frame_ready !== 1'b0) begin failures++; $display("FAIL idle_ready: %b exp 0", frame_ready); end
        cyc(0, 0, 0, 0, 0, 1, 0, 0, 0);
        checks++;
        if (rd_bank !== 1'b0) begin failures++; $display("FAIL idle_rsof: rd_bank %b exp 0", rd_bank); end
        cyc(0, 0, 0, 0, 0, 1, 1, 19'd0, 8'h5A);
        drain("oor");
    endtask

    task automatic test_reset_mid();
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 0, 0, 0);
        cyc(1, 0, 1, 19'd0, 8'h60, 0, 0, 0, 0);
        for (int i = 1; i < 10; i++) cyc(0, 0, 1, 19'(i), 8'(8'h60 + i), 0, 0, 0, 0);
        rst = 1'b1;
        cyc(1, 1, 1, 19'd0, 8'hFF, 1, 1, 19'd0, 8'h00);
        rst = 1'b0;
        checks += 4;
        if (frame_ready !== 1'b0) begin failures++; $display("FAIL mid_ready: %b exp 0", frame_ready); end
        if (wr_bank !== 1'b1) begin failures++; $display("FAIL mid_wr_bank: %b exp 1", wr_bank); end
        if (rd_bank !== 1'b0) begin failures++; $display("FAIL mid_rd_bank: %b exp 0", rd_bank); end
        if (rd_valid !== 1'b0) begin failures++; $display("FAIL mid_valid: %b exp 0", rd_valid); end
`ifdef FB_DROP_CNT_EN
        checks++;
        if (drop_cnt !== 16'd0) begin failures++; $display("FAIL mid_drop: %0d exp 0", drop_cnt); end
`endif
        cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (frame_ready !== 1'b0) begin failures++; $display("FAIL mid_eof: %b exp 0", frame_ready); end
        cyc(0, 0, 0, 0, 0, 0, 1, 19'd0, 8'h60);
        cyc(0, 0, 0, 0, 0, 0, 1, 19'd3, 8'h63);
        cyc(0, 0, 0, 0, 0, 0, 1, 19'd9, 8'h69);
        drain("mid");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_drop();
        test_same_cycle();
        test_out_of_range();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/frame_buffer_pp.md
FRAME_BUFFER_PP -- requirements
Module: frame_buffer_pp

Interface
REQ-001 SHALL have parameter DATA_W, default 8, pixel/byte width.
REQ-002 SHALL have parameter ADDR_W, default 19, per-frame address width.
REQ-003 SHALL have parameter DEPTH, default 307200, words per bank (640x480).
REQ-004 SHALL have ports: clk  in  1  sole clock, all logic on rising edge.
REQ-005 SHALL have ports: rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have ports: wr_sof  in  1  writer start-of-frame pulse; wr_eof  in  1  writer end-of-frame pulse.
REQ-007 SHALL have ports: wr_en  in  1  write strobe; wr_addr  in  ADDR_W  word address; wr_data  in  DATA_W  write data.
REQ-008 SHALL have ports: rd_sof  in  1  reader start-of-frame pulse; rd_en  in  1  read strobe; rd_addr  in  ADDR_W  word address.
REQ-009 SHALL have ports: rd_data  out  DATA_W  read data; rd_valid  out  1  rd_data qualifier.
REQ-010 SHALL have ports: frame_ready  out  1  completed frame awaiting reader; wr_bank  out  1  bank owned by writer; rd_bank  out  1  bank owned by reader.
REQ-011 SHALL have port drop_cnt  out  16  dropped-frame count, present only under FB_DROP_CNT_EN.

Function
REQ-012 SHALL hold two banks of DEPTH words each; physical index = bank*DEPTH + addr; write and read ports independent, usable in the same cycle.
REQ-013 SHALL always satisfy wr_bank != rd_bank.
REQ-014 Writer FSM states: W_IDLE, W_FILL, W_HOLD; frame_ready = (state == W_HOLD).
REQ-015 W_IDLE: wr_sof -> W_FILL; wr_eof, wr_en ignored.
REQ-016 W_FILL: wr_en writes wr_data to wr_bank at wr_addr; wr_eof -> W_HOLD; wr_sof restarts W_FILL, no drop count.
REQ-017 W_HOLD, rd_sof alone: swap banks, -> W_IDLE.
REQ-018 W_HOLD, wr_sof without rd_sof: -> W_FILL on same wr_bank, previous frame discarded, drop_cnt += 1.
REQ-019 W_HOLD, rd_sof and wr_sof same cycle: swap banks, -> W_FILL on the new wr_bank, no drop.
REQ-020 wr_en in the same cycle as wr_sof SHALL write (first pixel); wr_en in the same cycle as wr_eof SHALL write (last pixel).
REQ-021 rd_sof outside W_HOLD: no swap, reader re-reads current rd_bank.
REQ-022 Bank swap SHALL take effect the cycle after rd_sof; reads issued in the rd_sof cycle use the old rd_bank.
REQ-023 Read latency exactly 1: rd_en in cycle N -> rd_valid=1, rd_data=mem[rd_bank(N)][rd_addr(N)] in cycle N+1; rd_valid=0 otherwise; rd_data holds last value when rd_valid=0.
REQ-024 wr_addr >= DEPTH: write dropped. rd_addr >= DEPTH: rd_valid=1, rd_data=0.
REQ-025 Same-bank same-address read and write in one cycle cannot occur (REQ-013); no bypass required.
REQ-026 drop_cnt SHALL saturate at 16'hFFFF.

Reset
REQ-027 On rst: state W_IDLE, frame_ready=0, wr_bank=1, rd_bank=0, rd_valid=0, rd_data=0, drop_cnt=0.
REQ-028 Memory contents SHALL NOT be reset; rst mid-frame aborts the frame, no drop counted.
REQ-029 All inputs SHALL be ignored in a cycle with rst=1.

Configuration
REQ-030 Macro FB_DROP_CNT_EN defined: drop_cnt port and counter present per REQ-018/REQ-026.
REQ-031 Macro FB_DROP_CNT_EN undefined: no drop_cnt port, no counter logic; all other behaviour identical.

Verification
REQ-032 Reset, then wr_sof, write addr 0..3 = 8'h11..8'h44, wr_eof -> frame_ready=1, wr_bank=1, rd_bank=0.
REQ-033 Then rd_sof, next cycle rd_en addr 2 -> cycle after: rd_valid=1, rd_data=8'h33, rd_bank=1, wr_bank=0, frame_ready=0.
REQ-034 Two complete writer frames (addr 0 = 8'hAA then 8'hBB) without rd_sof -> drop_cnt=1; after rd_sof, read addr 0 returns 8'hBB.
REQ-035 rd_sof and wr_sof same cycle in W_HOLD -> banks swap, drop_cnt unchanged, writes land in new wr_bank, old frame readable unaltered.
REQ-036 wr_addr=307200 with wr_en -> no memory change; rd_addr=307200 -> rd_valid=1, rd_data=0.
REQ-037 rst asserted in W_FILL after 10 writes -> state W_IDLE, frame_ready=0, wr_bank=1, rd_bank=0, drop_cnt=0.
